// File: rtl/eth_apb_pkg.sv
// Shared register map, CTRL bit positions and STATUS field layout for the
// APB-attached Ethernet stream interface.
package eth_apb_pkg;

    localparam int APB_DW = 32;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_RXDATA = 4'hC;

    localparam int CTRL_WREN       = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_IRQ_RX_EN  = 2;
    localparam int CTRL_IRQ_TXE_EN = 3;
    localparam int CTRL_TX_FLUSH   = 8;
    localparam int CTRL_RX_FLUSH   = 9;

    localparam int ST_TX_COUNT_LSB = 0;
    localparam int ST_TX_COUNT_MSB = 7;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_RX_COUNT_MSB = 15;
    localparam int ST_TX_FULL      = 16;
    localparam int ST_TX_EMPTY     = 17;
    localparam int ST_RX_FULL      = 18;
    localparam int ST_RX_EMPTY     = 19;
    localparam int ST_RX_OVF       = 20;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; push while full and
// pop while empty are ignored, flush overrides both.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s, do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i & ~full_o & ~flush_i;
    assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
    assign count_o   = count_q;
    // Head is forced to zero when empty so it never shows stale storage.
    assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_eth_stream_if.sv
// APB control/data block for the Ethernet path: TX enable, TX/RX byte FIFOs
// bridging APB to MAC valid/ready streams, status, sticky overflow and irq.
module apb_eth_stream_if
    import eth_apb_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DW       = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              wren,
    output logic [DW-1:0]     tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DW-1:0]     rx_data,
    input  logic              rx_valid,
    output logic              irq
);
    logic access_s, wr_s, oor_s, unused_s;
    logic [3:0] off_s;
    logic ctrl_sel_s, status_sel_s, txd_sel_s, rxd_sel_s;
    logic tx_flush_s, rx_flush_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, ovf_set_s;
    logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [$clog2(TX_DEPTH):0] tx_count_s;
    logic [$clog2(RX_DEPTH):0] rx_count_s;
    logic [DW-1:0] rx_head_s;
    logic [APB_DW-1:0] status_s, ctrl_rd_s;
    logic wren_q, wren_d, pend_q, pend_d, rx_en_q, rx_en_d;
    logic irq_rx_en_q, irq_rx_en_d, irq_txe_en_q, irq_txe_en_d;
    logic rx_ovf_q, rx_ovf_d, irq_q, irq_d;

    generate
        if (ADDR_W > 4) begin : g_hi_addr
            assign oor_s = |paddr[ADDR_W-1:4];
        end else begin : g_no_hi_addr
            assign oor_s = 1'b0;
        end
    endgenerate

    assign access_s     = psel & penable;
    assign wr_s         = access_s & pwrite;
    assign off_s        = {paddr[3:2], 2'b00};
    assign ctrl_sel_s   = ~oor_s & (off_s == OFF_CTRL);
    assign status_sel_s = ~oor_s & (off_s == OFF_STATUS);
    assign txd_sel_s    = ~oor_s & (off_s == OFF_TXDATA);
    assign rxd_sel_s    = ~oor_s & (off_s == OFF_RXDATA);
    assign unused_s     = ^{paddr[1:0], pwdata};

    assign tx_flush_s = wr_s & ctrl_sel_s & pwdata[CTRL_TX_FLUSH];
    assign rx_flush_s = wr_s & ctrl_sel_s & pwdata[CTRL_RX_FLUSH];
    assign tx_push_s  = wr_s & txd_sel_s;
    assign tx_valid   = wren_q & ~tx_empty_s;
    assign tx_pop_s   = tx_valid & tx_ready;
    assign rx_push_s  = rx_valid & rx_en_q & ~rx_full_s;
    assign rx_pop_s   = access_s & ~pwrite & rxd_sel_s;
    assign ovf_set_s  = rx_valid & rx_en_q & rx_full_s & ~rx_flush_s;

    sync_fifo #(.DW(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(pclk), .rstn_i(rstn), .push_i(tx_push_s), .pop_i(tx_pop_s),
        .flush_i(tx_flush_s), .wdata_i(pwdata[DW-1:0]), .rdata_o(tx_data),
        .count_o(tx_count_s), .full_o(tx_full_s), .empty_o(tx_empty_s)
    );

    sync_fifo #(.DW(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(pclk), .rstn_i(rstn), .push_i(rx_push_s), .pop_i(rx_pop_s),
        .flush_i(rx_flush_s), .wdata_i(rx_data), .rdata_o(rx_head_s),
        .count_o(rx_count_s), .full_o(rx_full_s), .empty_o(rx_empty_s)
    );

    assign status_s  = {11'd0, rx_ovf_q, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s,
                        8'(rx_count_s), 8'(tx_count_s)};
    assign ctrl_rd_s = {28'd0, irq_txe_en_q, irq_rx_en_q, rx_en_q, wren_q};

    // Next-state for CTRL, the deferred wren drop, sticky overflow and irq.
    always_comb begin
        wren_d       = wren_q;
        pend_d       = pend_q;
        rx_en_d      = rx_en_q;
        irq_rx_en_d  = irq_rx_en_q;
        irq_txe_en_d = irq_txe_en_q;
        if (wr_s & ctrl_sel_s) begin
            rx_en_d      = pwdata[CTRL_RX_EN];
            irq_rx_en_d  = pwdata[CTRL_IRQ_RX_EN];
            irq_txe_en_d = pwdata[CTRL_IRQ_TXE_EN];
            if (pwdata[CTRL_WREN]) begin
                wren_d = 1'b1;
                pend_d = 1'b0;
            end else if (tx_valid & ~tx_ready & ~tx_flush_s) begin
                // A word is on offer and not yet taken: keep it stable.
                pend_d = 1'b1;
            end else begin
                wren_d = 1'b0;
                pend_d = 1'b0;
            end
        end else if (pend_q & tx_pop_s) begin
            wren_d = 1'b0;
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (ovf_set_s) begin
            rx_ovf_d = 1'b1;
        end else if (wr_s & status_sel_s & pwdata[ST_RX_OVF]) begin
            rx_ovf_d = 1'b0;
        end else begin
            rx_ovf_d = rx_ovf_q;
        end

        irq_d = (irq_rx_en_q & ~rx_empty_s) | (irq_txe_en_q & tx_empty_s) | rx_ovf_q;
    end

    // Control and flag registers.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            wren_q       <= 1'b0;
            pend_q       <= 1'b0;
            rx_en_q      <= 1'b0;
            irq_rx_en_q  <= 1'b0;
            irq_txe_en_q <= 1'b0;
            rx_ovf_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            wren_q       <= wren_d;
            pend_q       <= pend_d;
            rx_en_q      <= rx_en_d;
            irq_rx_en_q  <= irq_rx_en_d;
            irq_txe_en_q <= irq_txe_en_d;
            rx_ovf_q     <= rx_ovf_d;
            irq_q        <= irq_d;
        end
    end

    // Zero-wait read data and error response for the ACCESS phase.
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access_s) begin
            if (oor_s) begin
                pslverr = 1'b1;
            end else begin
                case (off_s)
                    OFF_CTRL:   prdata = pwrite ? '0 : ctrl_rd_s;
                    OFF_STATUS: prdata = pwrite ? '0 : status_s;
                    OFF_TXDATA: pslverr = pwrite ? tx_full_s : 1'b1;
                    OFF_RXDATA: begin
                        if (pwrite) begin
                            pslverr = 1'b1;
                        end else begin
                            prdata  = APB_DW'(rx_head_s);
                            pslverr = rx_empty_s;
                        end
                    end
                    default:    pslverr = 1'b1;
                endcase
            end
        end else begin
            prdata = '0;
        end
    end

    assign pready = 1'b1;
    assign wren   = wren_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_apb_eth_stream_if.sv
// Directed bench for apb_eth_stream_if with default parameters (DW=8, depths 16).
module tb_apb_eth_stream_if;
    logic        pclk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  paddr = 4'h0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr, wren, tx_valid, irq;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rdv;
    logic        errv;

    always #5 pclk = ~pclk;

    apb_eth_stream_if dut (
        .pclk(pclk), .rstn(rstn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .wren(wren), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        rd = prdata;
        er = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [3:0] addr, input logic [31:0] wd,
                          input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb(1'b1, addr, wd, d, e);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp_d,
                          input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb(1'b0, addr, 32'h0, d, e);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rx_strobes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            rx_valid = 1'b1;
            rx_data  = base + 8'(i);
        end
        @(negedge pclk);
        rx_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge pclk);
        rstn = 1'b1;
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_wren", {31'd0, wren}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_pready", {31'd0, pready}, 32'd1);
        rd_chk("rst_status", 4'h4, 32'h000A_0000, 1'b0);

        // TX path
        tx_ready = 1'b1;
        wr_chk("tx_push0", 4'h8, 32'h11, 1'b0);
        wr_chk("tx_push1", 4'h8, 32'h22, 1'b0);
        wr_chk("tx_push2", 4'h8, 32'h33, 1'b0);
        rd_chk("tx_status3", 4'h4, 32'h0008_0003, 1'b0);
        wr_chk("tx_wren_on", 4'h0, 32'h1, 1'b0);
        #1;
        check("tx_v0", {31'd0, tx_valid}, 32'd1);
        check("tx_d0", {24'd0, tx_data}, 32'h11);
        @(negedge pclk); #1;
        check("tx_d1", {24'd0, tx_data}, 32'h22);
        @(negedge pclk); #1;
        check("tx_d2", {24'd0, tx_data}, 32'h33);
        @(negedge pclk); #1;
        check("tx_drained_valid", {31'd0, tx_valid}, 32'd0);
        rd_chk("tx_status_empty", 4'h4, 32'h000A_0000, 1'b0);
        wr_chk("tx_wren_off", 4'h0, 32'h0, 1'b0);
        check("tx_wren_dropped", {31'd0, wren}, 32'd0);

        // TX full: 16 accepted, 17th rejected
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr_chk("full_push", 4'h8, 32'hA0 + 32'(i), 1'b0);
        wr_chk("full_push17", 4'h8, 32'hFF, 1'b1);
        rd_chk("full_status", 4'h4, 32'h0009_0010, 1'b0);
        wr_chk("full_wren_on", 4'h0, 32'h1, 1'b0);
        #1;
        check("full_head", {24'd0, tx_data}, 32'hA0);
        // Push and pop on the same edge while full: push is rejected
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h8; pwdata = 32'hEE;
        @(negedge pclk);
        penable = 1'b1; tx_ready = 1'b1;
        #1;
        check("full_pushpop_err", {31'd0, pslverr}, 32'd1);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_ready = 1'b0;
        #1;
        check("full_pushpop_head", {24'd0, tx_data}, 32'hA1);
        rd_chk("full_pushpop_status", 4'h4, 32'h0008_000F, 1'b0);

        // Deferred wren drop while a word is on offer
        wr_chk("drop_wr", 4'h0, 32'h0, 1'b0);
        #1;
        check("drop_wren_held", {31'd0, wren}, 32'd1);
        check("drop_valid_held", {31'd0, tx_valid}, 32'd1);
        repeat (2) @(negedge pclk);
        #1;
        check("drop_data_stable", {24'd0, tx_data}, 32'hA1);
        check("drop_valid_stable", {31'd0, tx_valid}, 32'd1);
        tx_ready = 1'b1;
        @(negedge pclk); #1;
        tx_ready = 1'b0;
        check("drop_wren_low", {31'd0, wren}, 32'd0);
        check("drop_valid_low", {31'd0, tx_valid}, 32'd0);
        check("drop_next_head", {24'd0, tx_data}, 32'hA2);
        rd_chk("drop_status", 4'h4, 32'h0008_000E, 1'b0);
        wr_chk("drop_flush", 4'h0, 32'h100, 1'b0);
        rd_chk("drop_flushed", 4'h4, 32'h000A_0000, 1'b0);

        // TX-empty interrupt
        wr_chk("txe_irq_en", 4'h0, 32'h8, 1'b0);
        @(negedge pclk); #1;
        check("txe_irq", {31'd0, irq}, 32'd1);
        wr_chk("txe_irq_dis", 4'h0, 32'h0, 1'b0);
        @(negedge pclk); #1;
        check("txe_irq_clr", {31'd0, irq}, 32'd0);

        // RX overflow
        wr_chk("rx_en", 4'h0, 32'h2, 1'b0);
        rx_strobes(17, 8'h30);
        rd_chk("ovf_status", 4'h4, 32'h0016_1000, 1'b0);
        check("ovf_irq", {31'd0, irq}, 32'd1);
        wr_chk("ovf_w1c", 4'h4, 32'h0010_0000, 1'b0);
        rd_chk("ovf_cleared", 4'h4, 32'h0006_1000, 1'b0);
        check("ovf_irq_clr", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 16; i++) rd_chk("rx_pop", 4'hC, 32'h30 + 32'(i), 1'b0);
        rd_chk("rx_pop_empty", 4'hC, 32'h0, 1'b1);
        wr_chk("rxdata_write", 4'hC, 32'h5, 1'b1);
        rd_chk("txdata_read", 4'h8, 32'h0, 1'b1);
        wr_chk("rx_dis", 4'h0, 32'h0, 1'b0);
        rx_strobes(1, 8'h77);
        rd_chk("rx_dis_status", 4'h4, 32'h000A_0000, 1'b0);

        // Flush both FIFOs, then reset mid-stream
        wr_chk("fl_ctrl", 4'h0, 32'h6, 1'b0);
        for (int i = 0; i < 5; i++) wr_chk("fl_tx_push", 4'h8, 32'h51 + 32'(i), 1'b0);
        rx_strobes(5, 8'h61);
        rd_chk("fl_status", 4'h4, 32'h0000_0505, 1'b0);
        check("fl_irq_rx", {31'd0, irq}, 32'd1);
        wr_chk("fl_flush", 4'h0, 32'h306, 1'b0);
        rd_chk("fl_ctrl_rb", 4'h0, 32'h0000_0006, 1'b0);
        rd_chk("fl_status_empty", 4'h4, 32'h000A_0000, 1'b0);
        check("fl_irq_clr", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 5; i++) wr_chk("rs_tx_push", 4'h8, 32'h51 + 32'(i), 1'b0);
        rx_strobes(5, 8'h61);
        wr_chk("rs_wren", 4'h0, 32'h7, 1'b0);
        #1;
        check("rs_valid_before", {31'd0, tx_valid}, 32'd1);
        tx_ready = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h99;
        @(negedge pclk); #2;
        rstn = 1'b0;
        #1;
        check("rs_wren", {31'd0, wren}, 32'd0);
        check("rs_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rs_irq", {31'd0, irq}, 32'd0);
        check("rs_prdata", prdata, 32'd0);
        check("rs_pslverr", {31'd0, pslverr}, 32'd0);
        rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge pclk);
        rstn = 1'b1;
        rd_chk("rs_status", 4'h4, 32'h000A_0000, 1'b0);
        rd_chk("rs_ctrl", 4'h0, 32'h0, 1'b0);
        check("rs_irq_after", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_eth_stream_if.md
# apb_eth_stream_if

APB-attached control and data-buffering block for the Ethernet path. It replaces the single-bit enable peripheral. It keeps the `wren` TX-enable output and adds:
- a parametrised TX byte FIFO that software fills over APB and that drains to the MAC over a valid/ready stream;
- an RX byte FIFO that the MAC fills and software drains over APB;
- status and sticky error flags, and an interrupt.

It sits on the peripheral APB bus beside the other SoC slaves.

## Interface
Parameters:
- ADDR_W, 4: paddr width. Bits [1:0] are ignored.
- DW, 8: stream data width, 1..32.
- TX_DEPTH, 16: TX FIFO entries. Must be a power of two, 2..128.
- RX_DEPTH, 16: RX FIFO entries. Must be a power of two, 2..128.

Ports:
- pclk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- paddr  in  ADDR_W  byte address.
- psel / penable / pwrite  in  1  APB controls.
- pwdata  in  32  write data.
- prdata  out  32  read data. Valid in the ACCESS phase.
- pready  out  1  tied to 1 (zero wait states).
- pslverr  out  1  error, asserted in the ACCESS phase.
- wren  out  1  TX enable to the MAC (CTRL bit 0).
- tx_data  out  DW  TX FIFO head.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  MAC accept.
- rx_data  in  DW  received word.
- rx_valid  in  1  single-cycle strobe. It has no backpressure.
- irq  out  1  level interrupt, registered.

## Operation
- An access completes when psel & penable are high. All register effects commit on that pclk edge.
- Register map (offset = paddr[3:2]*4):
  - **0x0 CTRL (RW)**
    - [0] wren, [1] rx_en, [2] irq_rx_en, [3] irq_txe_en.
    - [8] tx_flush and [9] rx_flush are write-1 pulses. They are not stored and read back as 0.
  - **0x4 STATUS (RO, except bit 20 W1C)**
    - [7:0] tx_count, [15:8] rx_count.
    - [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty.
    - [20] rx_ovf, sticky.
  - **0x8 TXDATA (WO)**
    - Write pushes pwdata[DW-1:0].
    - If the FIFO is full: pslverr=1, data dropped, no state change.
    - Read returns 0 with pslverr=1.
  - **0xC RXDATA (RO)**
    - Read returns the FIFO head zero-extended to 32 bits and pops it.
    - If the FIFO is empty: prdata=0, pslverr=1.
    - Write: pslverr=1, ignored.
  - Offsets ≥ 0x10 (only when ADDR_W > 4): read 0, pslverr=1.
- prdata is 0 whenever no read access is active. pslverr is 0 outside the ACCESS phase.
- **TX stream**
  - tx_valid = wren_eff & !tx_empty. tx_data is the first-word-fall-through head.
  - A transfer happens on tx_valid & tx_ready and pops one entry.
  - Once tx_valid is high it must stay high, with tx_data stable, until accepted.
  - A write clearing wren therefore sets a pending flag. wren and wren_eff drop on the edge after the in-flight handshake completes, or immediately if tx_valid is low.
- **RX stream**
  - If rx_valid & rx_en & !rx_full: push rx_data.
  - If rx_valid & rx_en & rx_full: drop the word and set rx_ovf.
  - If rx_en=0: ignore the word, no flag.
- **Flush:** empties the FIFO on the commit edge. tx_flush also clears any pending wren drop.
- **irq** (registered) = (irq_rx_en & !rx_empty) | (irq_txe_en & tx_empty) | rx_ovf.

## Timing
- Reset values:
  - CTRL = 0.
  - Both FIFOs empty; tx_empty=1, rx_empty=1.
  - rx_ovf=0, wren=0, tx_valid=0, irq=0, prdata=0, pslverr=0, pready=1.
- Reset mid-transfer aborts immediately; FIFO contents are discarded.
- APB TXDATA push to tx_valid high: 1 cycle when wren=1.
- rx_valid to rx_count visible in STATUS: 1 cycle.
- Condition to irq: 1 cycle.
- Simultaneous events:
  - Push and pop in the same cycle keep the count unchanged and are both legal, except a push while full, which is rejected because full is evaluated on the pre-edge count.
  - Pop on an empty FIFO is impossible by construction.
  - Flush wins over a same-cycle stream pop or rx push; that word is discarded and does not set rx_ovf.
  - rx_ovf set and W1C on the same edge: set wins.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Counts are $clog2(DEPTH)+1 bits, zero-extended into the 8-bit STATUS fields.

## Structure
- Package eth_apb_pkg holds:
  - the register offsets, CTRL bit indices, STATUS field LSBs/MSBs;
  - a localparam for the 32-bit APB data width.
- Sub-module sync_fifo, instantiated twice:
  - parameters DW and DEPTH;
  - ports: push, pop, flush, head data, count, full, empty;
  - first-word-fall-through.
- Top level: APB decode, CTRL/flag registers, wren drop logic, irq register.

## Test plan
- Reset release: STATUS reads 0x000A_0000, irq=0, wren=0, tx_valid=0.
- TX path:
  - Write TXDATA 0x11, 0x22, 0x33, then CTRL=0x1.
  - With tx_ready=1, expect tx_data 0x11, 0x22, 0x33 on three consecutive cycles.
  - tx_empty=1 afterwards.
- TX full:
  - Write 17 bytes with TX_DEPTH=16 and wren=0.
  - The 17th access gets pslverr=1; tx_count=16.
  - A simultaneous push and tx pop when full: push rejected.
- wren drop:
  - Hold tx_ready=0 with tx_valid high, then write CTRL=0.
  - tx_valid stays high and tx_data stays stable.
  - Raise tx_ready: one handshake, then wren=0.
- RX overflow:
  - Set rx_en and send 17 rx_valid strobes.
  - rx_count=16, rx_ovf=1, irq=1.
  - Write STATUS bit 20: rx_ovf clears.
  - Reads return the first 16 words in order; a 17th read gives prdata=0, pslverr=1.
- Flush and reset: with 5 bytes in each FIFO, write CTRL[9:8]=11, then assert rstn mid-stream. Both FIFOs empty, counts 0, all outputs at reset values.
